// File: rtl/stego_pkg.sv
// stego_pkg: shared encodings for the stego embed scheduler
package stego_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_EMBED   = 3'd2;
    localparam logic [2:0] S_RESP_WB = 3'd3;
    localparam logic [2:0] S_SHIFT_P = 3'd4;
    localparam logic REQ_WB = 1'b0;
    localparam logic REQ_P  = 1'b1;
    localparam int ST_FULL  = 7;
    localparam int ST_EMPTY = 6;
    localparam int ST_CNT   = 0;
    function automatic logic [7:0] status_byte(input logic full, input logic empty, input logic [3:0] cnt);
        logic [7:0] s;
        s = '0;
        s[ST_FULL] = full;
        s[ST_EMPTY] = empty;
        s[ST_CNT+:4] = cnt;
        return s;
    endfunction
endpackage

// File: rtl/msg_bit_fifo.sv
// msg_bit_fifo: single-bit message FIFO with occupancy count
module msg_bit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic push_ok, pop_ok;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout = mem_q[rd_q];
    assign count = cnt_q;
    always_comb begin
        push_ok = push & ~full;
        pop_ok = pop & ~empty;
        mem_d = mem_q;
        if (push_ok) mem_d[wr_q] = din;
        wr_d = wr_q + AW'(push_ok);
        rd_d = rd_q + AW'(pop_ok);
        cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/stego_embed_sched.sv
// stego_embed_sched: arbitrates one LSB-embed engine between a Wishbone
// requester and a serial pin requester, with key-XORed message bits.
module stego_embed_sched
    import stego_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int KEY_W = 8
) (
    input  logic       clk_wb,
    input  logic       rst_wb,
    input  logic       wb_cyc,
    input  logic       wb_stb,
    input  logic       wb_we,
    input  logic [7:0] cover_wb,
    output logic       wb_ack,
    output logic [7:0] out_wb,
    input  logic       cover_p,
    input  logic       cover_p_vld,
    output logic       out_p,
    output logic       out_p_vld,
    input  logic       msg_bit,
    input  logic       msg_vld,
    input  logic       key_bit,
    input  logic       key_ld,
    output logic       msg_full,
    output logic       busy
);
    localparam int KPW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int CW = $clog2(MSG_DEPTH) + 1;
    logic [2:0] state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KPW-1:0] kptr_q, kptr_d;
    logic prio_q, prio_d, gnt_q, gnt_d, ppend_q, ppend_d, ack_q, ack_d;
    logic [7:0] cover_q, cover_d, stego_q, stego_d, psh_q, psh_d, out_wb_q, out_wb_d;
    logic [2:0] pcnt_q, pcnt_d, bcnt_q, bcnt_d;
    logic fifo_dout, fifo_full, fifo_empty, wb_req, rd_req, tie, pin_acc;
    logic [CW-1:0] fifo_cnt;
    logic [3:0] cnt4;
    msg_bit_fifo #(.DEPTH(MSG_DEPTH)) u_fifo (
        .clk(clk_wb),
        .rst(rst_wb),
        .push(msg_vld),
        .din(msg_bit),
        .pop(state_q == S_EMBED),
        .dout(fifo_dout),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_cnt)
    );
    assign wb_req = wb_cyc & wb_stb & wb_we & ~ack_q;
    assign rd_req = wb_cyc & wb_stb & ~wb_we & ~ack_q;
    assign tie = wb_req & ppend_q;
    assign pin_acc = cover_p_vld & ~ppend_q & (state_q != S_SHIFT_P);
    assign cnt4 = (int'(fifo_cnt) > 15) ? 4'hF : 4'(fifo_cnt);
    assign busy = state_q != S_IDLE;
    assign msg_full = fifo_full;
    assign wb_ack = ack_q;
    assign out_wb = out_wb_q;
    assign out_p_vld = state_q == S_SHIFT_P;
    assign out_p = out_p_vld & stego_q[3'd7 - bcnt_q];
    always_comb begin
        state_d = state_q;
        key_d = key_q;
        kptr_d = kptr_q;
        prio_d = prio_q;
        gnt_d = gnt_q;
        cover_d = cover_q;
        stego_d = stego_q;
        bcnt_d = bcnt_q;
        psh_d = pin_acc ? {psh_q[6:0], cover_p} : psh_q;
        pcnt_d = pin_acc ? pcnt_q + 3'd1 : pcnt_q;
        ppend_d = ppend_q | (pin_acc & (pcnt_q == 3'd7));
        ack_d = (state_q == S_RESP_WB) | rd_req;
        out_wb_d = (state_q == S_RESP_WB) ? stego_q :
                   rd_req ? status_byte(fifo_full, fifo_empty, cnt4) : out_wb_q;
        if (key_ld && !busy) begin
            key_d = {key_q[KEY_W-2:0], key_bit};
            kptr_d = '0;
        end
        case (state_q)
            S_IDLE: state_d = ((wb_req | ppend_q) & ~fifo_empty) ? S_GRANT : S_IDLE;
            S_GRANT: begin
                // priority only rotates when both requesters contend
                gnt_d = tie ? prio_q : (wb_req ? REQ_WB : REQ_P);
                prio_d = tie ? ~prio_q : prio_q;
                cover_d = (gnt_d == REQ_WB) ? cover_wb : psh_q;
                state_d = (wb_req | ppend_q) ? S_EMBED : S_IDLE;
            end
            S_EMBED: begin
                stego_d = {cover_q[7:1], fifo_dout ^ key_q[kptr_q]};
                kptr_d = (kptr_q == KPW'(KEY_W - 1)) ? '0 : kptr_q + 1'b1;
                state_d = (gnt_q == REQ_P) ? S_SHIFT_P : (wb_cyc ? S_RESP_WB : S_IDLE);
            end
            S_RESP_WB: state_d = S_IDLE;
            S_SHIFT_P: begin
                bcnt_d = bcnt_q + 3'd1;
                state_d = (bcnt_q == 3'd7) ? S_IDLE : S_SHIFT_P;
                ppend_d = (bcnt_q == 3'd7) ? 1'b0 : ppend_q;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_wb or posedge rst_wb) begin
        if (rst_wb) begin
            state_q <= S_IDLE;
            key_q <= '0;
            kptr_q <= '0;
            prio_q <= REQ_WB;
            gnt_q <= REQ_WB;
            ppend_q <= 1'b0;
            ack_q <= 1'b0;
            cover_q <= '0;
            stego_q <= '0;
            psh_q <= '0;
            out_wb_q <= '0;
            pcnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            kptr_q <= kptr_d;
            prio_q <= prio_d;
            gnt_q <= gnt_d;
            ppend_q <= ppend_d;
            ack_q <= ack_d;
            cover_q <= cover_d;
            stego_q <= stego_d;
            psh_q <= psh_d;
            out_wb_q <= out_wb_d;
            pcnt_q <= pcnt_d;
            bcnt_q <= bcnt_d;
        end
    end
endmodule
